// File: rtl/mor1kx_branch_redirect_pkg.sv
// Shared definitions for the branch redirect unit.
//   br_state_t         : redirect controller state (idle / redirect pending)
//   BR_FALLTHRU_OFFSET : byte offset from a branch PC to the instruction after
//                        its delay slot (the not-taken fetch address)
package mor1kx_branch_redirect_pkg;

    typedef enum logic [0:0] {
        BR_IDLE     = 1'b0,
        BR_REDIRECT = 1'b1
    } br_state_t;

    localparam int unsigned BR_FALLTHRU_OFFSET = 8;

endpackage

// File: rtl/mor1kx_branch_redirect_if.sv
// Redirect request channel from the branch redirect unit to fetch.
//   valid : redirect request, held until ack
//   pc    : corrected fetch PC, stable while valid
//   ack   : fetch accepts the redirect
// master = redirect unit, slave = fetch.
interface mor1kx_branch_redirect_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic             ack;

    modport master (output valid, output pc, input ack);
    modport slave  (input valid, input pc, output ack);
endinterface

// File: rtl/mor1kx_sat_counter.sv
// Saturating up-counter for performance monitoring.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event
//   clr        : synchronous clear (wins over inc)
//   count      : current value, sticks at all-ones
module mor1kx_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mor1kx_branch_redirect.sv
// Holds the conditional branch in flight between decode and execute and,
// when execute reports a misprediction, redirects fetch to the corrected PC.
//   clk, rst_n              : clock, asynchronous active-low reset
//   padv_decode_i           : decode advances into execute
//   decode_op_bf_i/bnf_i    : decode instruction is l.bf / l.bnf
//   decode_predicted_flag_i : predicted flag for the decode branch
//   decode_brn_pc_i/target_i: branch PC and taken target
//   flag_valid_i            : execute flag of the captured branch is final
//   branch_mispredict_i     : misprediction, qualified by flag_valid_i
//   pipeline_flush_i        : exception/rfe flush, highest priority
//   redirect (master)       : valid/pc/ack redirect channel to fetch
//   flush_o                 : one-cycle wrong-path kill
//   decode_stall_o          : hold decode while a redirect is pending
//   branch_count_o          : resolved conditional branches (saturating)
//   mispredict_count_o      : resolved mispredictions (saturating)
module mor1kx_branch_redirect
    import mor1kx_branch_redirect_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned CNT_WIDTH            = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            padv_decode_i,
    input  logic                            decode_op_bf_i,
    input  logic                            decode_op_bnf_i,
    input  logic                            decode_predicted_flag_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_brn_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_brn_target_i,
    input  logic                            flag_valid_i,
    input  logic                            branch_mispredict_i,
    input  logic                            pipeline_flush_i,
    mor1kx_branch_redirect_if.master        redirect,
    output logic                            flush_o,
    output logic                            decode_stall_o,
    output logic [CNT_WIDTH-1:0]            branch_count_o,
    output logic [CNT_WIDTH-1:0]            mispredict_count_o
);

    br_state_t                       state;
    br_state_t                       state_next;
    logic                            cap_valid;
    logic [OPTION_OPERAND_WIDTH-1:0] cap_pc;
    logic [OPTION_OPERAND_WIDTH-1:0] cap_target;
    logic                            cap_pt;
    logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc;
    logic                            flush;

    logic is_branch;
    logic pred_taken;
    logic resolve;
    logic mispredict;
    logic capture;

    always_comb begin
        is_branch  = decode_op_bf_i | decode_op_bnf_i;
        pred_taken = (decode_op_bf_i & decode_predicted_flag_i) |
                     (decode_op_bnf_i & ~decode_predicted_flag_i);
        // Both resolve and capture only act in IDLE and lose to a pipeline flush.
        resolve    = (state == BR_IDLE) & cap_valid & flag_valid_i & ~pipeline_flush_i;
        mispredict = resolve & branch_mispredict_i;
        capture    = (state == BR_IDLE) & padv_decode_i & ~pipeline_flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (pipeline_flush_i) begin
            state_next = BR_IDLE;
        end else begin
            case (state)
                BR_IDLE:     if (mispredict)   state_next = BR_REDIRECT;
                BR_REDIRECT: if (redirect.ack) state_next = BR_IDLE;
                default:                       state_next = BR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid   <= 1'b0;
            cap_pc      <= '0;
            cap_target  <= '0;
            cap_pt      <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
        end else begin
            flush <= mispredict;

            // A branch captured alongside a mispredicting resolve is on the
            // wrong path, so it is loaded but never marked valid.
            if (pipeline_flush_i) begin
                cap_valid <= 1'b0;
            end else if (capture) begin
                cap_valid <= is_branch & ~mispredict;
            end else if (resolve) begin
                cap_valid <= 1'b0;
            end

            if (capture && is_branch) begin
                cap_pc     <= decode_brn_pc_i;
                cap_target <= decode_brn_target_i;
                cap_pt     <= pred_taken;
            end

            if (mispredict) begin
                redirect_pc <= cap_pt ?
                    cap_pc + OPTION_OPERAND_WIDTH'(BR_FALLTHRU_OFFSET) :
                    cap_target;
            end
        end
    end

    assign redirect.valid = (state == BR_REDIRECT);
    assign redirect.pc    = redirect_pc;
    assign flush_o        = flush;
    assign decode_stall_o = (state == BR_REDIRECT);

    mor1kx_sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resolve),
        .clr   (1'b0),
        .count (branch_count_o)
    );

    mor1kx_sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mispredict),
        .clr   (1'b0),
        .count (mispredict_count_o)
    );

endmodule

// File: tb/tb_mor1kx_branch_redirect.sv
// Bench for mor1kx_branch_redirect: two instances (16-bit and 2-bit counters)
// share one stimulus stream; a behavioural model tracks the pending branch and
// redirect, pushes expected redirects into a scoreboard queue, and a negedge
// monitor compares every output and pops the queue on each flush pulse.
module tb_mor1kx_branch_redirect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        padv, bf, bnf, pred, flag_valid, mispred, pflush, ack;
    logic [31:0] brn_pc, brn_tgt;

    logic        flush1, stall1, flush2, stall2;
    logic [15:0] bcnt1, mcnt1;
    logic [1:0]  bcnt2, mcnt2;

    int n_cmp = 0;
    int n_bad = 0;

    mor1kx_branch_redirect_if #(.WIDTH(32)) rif1 ();
    mor1kx_branch_redirect_if #(.WIDTH(32)) rif2 ();
    assign rif1.ack = ack;
    assign rif2.ack = ack;

    mor1kx_branch_redirect #(.OPTION_OPERAND_WIDTH(32), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .padv_decode_i(padv),
        .decode_op_bf_i(bf), .decode_op_bnf_i(bnf), .decode_predicted_flag_i(pred),
        .decode_brn_pc_i(brn_pc), .decode_brn_target_i(brn_tgt),
        .flag_valid_i(flag_valid), .branch_mispredict_i(mispred),
        .pipeline_flush_i(pflush), .redirect(rif1), .flush_o(flush1),
        .decode_stall_o(stall1), .branch_count_o(bcnt1), .mispredict_count_o(mcnt1));

    mor1kx_branch_redirect #(.OPTION_OPERAND_WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .padv_decode_i(padv),
        .decode_op_bf_i(bf), .decode_op_bnf_i(bnf), .decode_predicted_flag_i(pred),
        .decode_brn_pc_i(brn_pc), .decode_brn_target_i(brn_tgt),
        .flag_valid_i(flag_valid), .branch_mispredict_i(mispred),
        .pipeline_flush_i(pflush), .redirect(rif2), .flush_o(flush2),
        .decode_stall_o(stall2), .branch_count_o(bcnt2), .mispredict_count_o(mcnt2));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rpc;
        int unsigned bcnt;
        int unsigned mcnt;
    } exp_t;

    exp_t        sbq[$];
    bit          m_pend = 0, m_pt = 0, m_redir = 0, m_first = 0;
    logic [31:0] m_pc = '0, m_tgt = '0, m_rpc = '0;
    int unsigned m_bcnt = 0, m_mcnt = 0;
    bit          m_res, m_mis;

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
        int unsigned mx;
        mx = (32'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend = 0; m_redir = 0; m_first = 0; m_rpc = '0;
                m_bcnt = 0; m_mcnt = 0;
                sbq.delete();
            end else begin
                m_first = 0;
                if (pflush) begin
                    m_pend  = 0;
                    m_redir = 0;
                end else if (m_redir) begin
                    if (ack) m_redir = 0;
                end else begin
                    m_res = m_pend && flag_valid;
                    m_mis = m_res && mispred;
                    if (m_res) m_bcnt++;
                    if (m_mis) begin
                        m_mcnt++;
                        m_rpc   = m_pt ? m_pc + 32'd8 : m_tgt;
                        m_redir = 1;
                        m_first = 1;
                        sbq.push_back(exp_t'{rpc: m_rpc, bcnt: m_bcnt, mcnt: m_mcnt});
                    end
                    if (padv) begin
                        m_pend = (bf || bnf) && !m_mis;
                        if (bf || bnf) begin
                            m_pc  = brn_pc;
                            m_tgt = brn_tgt;
                            m_pt  = (bf && pred) || (bnf && !pred);
                        end
                    end else if (m_res) begin
                        m_pend = 0;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("valid1", {31'd0, rif1.valid}, {31'd0, m_redir});
            chk("stall1", {31'd0, stall1}, {31'd0, m_redir});
            chk("flush1", {31'd0, flush1}, {31'd0, m_first});
            chk("valid2", {31'd0, rif2.valid}, {31'd0, m_redir});
            chk("flush2", {31'd0, flush2}, {31'd0, m_first});
            chk("rpc1", rif1.pc, m_rpc);
            chk("rpc2", rif2.pc, m_rpc);
            chk("bcnt1", {16'd0, bcnt1}, sat(m_bcnt, 16));
            chk("mcnt1", {16'd0, mcnt1}, sat(m_mcnt, 16));
            chk("bcnt2", {30'd0, bcnt2}, sat(m_bcnt, 2));
            chk("mcnt2", {30'd0, mcnt2}, sat(m_mcnt, 2));
            if (flush1) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_rpc", rif1.pc, e.rpc);
                    chk("sb_bcnt", {16'd0, bcnt1}, sat(e.bcnt, 16));
                    chk("sb_mcnt2", {30'd0, mcnt2}, sat(e.mcnt, 2));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        padv = 0; bf = 0; bnf = 0; pred = 0; flag_valid = 0;
        mispred = 0; pflush = 0; ack = 0; brn_pc = '0; brn_tgt = '0;
    endtask

    task automatic issue(input logic ibf, input logic ibnf, input logic ipred,
                         input logic [31:0] ipc, input logic [31:0] itgt);
        padv = 1; bf = ibf; bnf = ibnf; pred = ipred; brn_pc = ipc; brn_tgt = itgt;
        step();
        idle_in();
    endtask

    task automatic resolve(input logic mis);
        flag_valid = 1; mispred = mis;
        step();
        idle_in();
    endtask

    task automatic do_ack();
        ack = 1;
        step();
        idle_in();
    endtask

    logic [15:0] b_before, m_before;

    initial begin
        idle_in();
        rst_n = 0;
        #2;
        chk("rst_valid", {31'd0, rif1.valid}, 32'd0);
        chk("rst_pc", rif1.pc, 32'd0);
        chk("rst_flush", {31'd0, flush1}, 32'd0);
        chk("rst_stall", {31'd0, stall1}, 32'd0);
        chk("rst_cnt", {bcnt1, mcnt1}, 32'd0);
        step(); step();
        rst_n = 1;
        step();

        // bf predicted taken, actually not taken: fallthrough past delay slot
        issue(1, 0, 1, 32'h1000, 32'h2000);
        resolve(1);
        chk("tp1_pc", rif1.pc, 32'h0000_1008);
        chk("tp1_flush", {31'd0, flush1}, 32'd1);
        chk("tp1_cnt", {bcnt1, mcnt1}, {16'd1, 16'd1});
        step();
        chk("tp1_flush_once", {31'd0, flush1}, 32'd0);
        do_ack();
        chk("tp1_ack_valid", {31'd0, rif1.valid}, 32'd0);

        // bnf predicted not taken, actually taken; fetch stalls on ack
        issue(0, 1, 1, 32'h1000, 32'h3000);
        resolve(1);
        for (int unsigned i = 0; i < 5; i++) begin
            padv = 1; bf = 1; pred = 1; brn_pc = 32'h5000 + 32'(i * 4); brn_tgt = 32'h6000;
            step();
            chk("tp2_hold_pc", rif1.pc, 32'h0000_3000);
            chk("tp2_stall", {31'd0, stall1}, 32'd1);
        end
        idle_in();
        do_ack();
        resolve(1); // nothing captured during the stall: must be ignored
        chk("tp2_no_capture", {31'd0, rif1.valid}, 32'd0);

        // correct prediction
        b_before = bcnt1; m_before = mcnt1;
        issue(1, 0, 0, 32'h4000, 32'h4800);
        resolve(0);
        chk("tp3_bcnt", {16'd0, bcnt1}, {16'd0, b_before + 16'd1});
        chk("tp3_mcnt", {16'd0, mcnt1}, {16'd0, m_before});

        // fallthrough wraps at the top of the address space
        issue(1, 0, 1, 32'hFFFF_FFFC, 32'h0000_0100);
        resolve(1);
        chk("tp4_wrap_pc", rif1.pc, 32'h0000_0004);
        do_ack();

        // flush coincident with a mispredicting resolve
        issue(0, 1, 0, 32'h7000, 32'h7400);
        b_before = bcnt1; m_before = mcnt1;
        flag_valid = 1; mispred = 1; pflush = 1;
        step();
        idle_in();
        chk("tp5_valid", {31'd0, rif1.valid}, 32'd0);
        chk("tp5_cnt", {bcnt1, mcnt1}, {b_before, m_before});
        resolve(1); // capture was flushed: ignored

        // flush in the middle of a redirect drops it without ack
        issue(1, 0, 1, 32'h8000, 32'h8800);
        resolve(1);
        step();
        pflush = 1;
        step();
        idle_in();
        chk("tp6_valid", {31'd0, rif1.valid}, 32'd0);

        // fifth mispredict: 2-bit counter saturates at 3
        issue(1, 0, 0, 32'h9000, 32'h9100);
        resolve(1);
        do_ack();
        chk("tp7_mcnt2_sat", {30'd0, mcnt2}, 32'd3);
        chk("tp7_mcnt1", {16'd0, mcnt1}, 32'd5);

        // asynchronous reset while a redirect is pending
        issue(1, 0, 1, 32'hA000, 32'hA100);
        resolve(1);
        #2;
        rst_n = 0;
        #1;
        chk("tp8_valid", {31'd0, rif1.valid}, 32'd0);
        chk("tp8_stall", {31'd0, stall1}, 32'd0);
        chk("tp8_flush", {31'd0, flush1}, 32'd0);
        chk("tp8_pc", rif1.pc, 32'd0);
        chk("tp8_cnt", {bcnt1, mcnt1}, 32'd0);
        step();
        rst_n = 1;
        step();

        // randomized traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            int unsigned op;
            op         = $urandom_range(0, 2);
            padv       = ($urandom_range(0, 99) < 60);
            bf         = (op == 1);
            bnf        = (op == 2);
            pred       = $urandom_range(0, 1);
            brn_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'd3);
            brn_tgt    = $urandom & ~32'd3;
            flag_valid = ($urandom_range(0, 99) < 35);
            mispred    = ($urandom_range(0, 99) < 40);
            pflush     = ($urandom_range(0, 99) < 3);
            ack        = ($urandom_range(0, 99) < 40);
            step();
        end
        idle_in();
        ack = 1;
        step(); step();
        idle_in();
        step();
        chk("sb_drained", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
